// File: rtl/v0_display_driver_pkg.sv
// ============================================================================
// Module      : v0_display_driver_pkg
// Description : Shared constants for the $v0 7-segment display driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package v0_display_driver_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {a,b,c,d,e,f,g} patterns for hex digits 0..F
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

`default_nettype wire

// File: rtl/v0_display_driver_hex_to_7seg.sv
// ============================================================================
// Module      : hex_to_7seg
// Description : Combinational hex nibble to active-low 7-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_to_7seg
    import v0_display_driver_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_HEX[i_nibble];

endmodule

`default_nettype wire

// File: rtl/v0_display_driver.sv
// ============================================================================
// Module      : v0_display_driver
// Description : Multiplexes a frame-snapshotted 32-bit value, one halfword
//               page at a time, onto a 4-digit common-anode display.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module v0_display_driver
    import v0_display_driver_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int PAGE_FRAMES  = 500
) (
    input  logic        clk,
    input  logic        reset_in,
    input  logic [31:0] value_in,
    input  logic        hold_in,
    input  logic        auto_page_in,
    input  logic        manual_page_in,
    output logic [6:0]  seg_out,
    output logic [3:0]  digit_out,
    output logic        page_out
);

    localparam int c_SCAN_W  = $clog2(SCAN_DIV);
    localparam int c_FRAME_W = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;

    localparam logic [c_SCAN_W-1:0]  c_SCAN_LAST  = c_SCAN_W'(SCAN_DIV - 1);
    localparam logic [c_SCAN_W-1:0]  c_BLANK      = c_SCAN_W'(BLANK_CYCLES);
    localparam logic [c_FRAME_W-1:0] c_FRAME_LAST = c_FRAME_W'(PAGE_FRAMES - 1);
    localparam logic [1:0]           c_LAST_DIGIT = 2'(NUM_DIGITS - 1);

    logic [c_SCAN_W-1:0]  r_scan_cnt;
    logic [1:0]           r_digit_idx;
    logic [c_FRAME_W-1:0] r_frame_cnt;
    logic                 r_page;
    logic [31:0]          r_snapshot;

    logic                 w_tick;
    logic                 w_frame_end;
    logic [3:0]           w_nibble;
    logic [6:0]           w_seg;

    assign w_tick      = (r_scan_cnt == c_SCAN_LAST);
    assign w_frame_end = w_tick && (r_digit_idx == c_LAST_DIGIT);
    assign w_nibble    = r_snapshot[{r_page, r_digit_idx, 2'b00} +: 4];

    hex_to_7seg u_hex_to_7seg (
        .i_nibble (w_nibble),
        .o_seg    (w_seg)
    );

    // Scan, page and snapshot state
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= '0;
            r_frame_cnt <= '0;
            r_page      <= 1'b0;
            r_snapshot  <= value_in;
        end else if (w_tick) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= r_digit_idx + 2'd1;
            if (w_frame_end) begin
                if (!hold_in) begin
                    r_snapshot <= value_in;
                end
                if (auto_page_in) begin
                    if (r_frame_cnt == c_FRAME_LAST) begin
                        r_frame_cnt <= '0;
                        r_page      <= ~r_page;
                    end else begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                    end
                end else begin
                    r_page      <= manual_page_in;
                    r_frame_cnt <= '0;
                end
            end
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Registered outputs lag the scan state by one cycle
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            digit_out <= 4'b1111;
            seg_out   <= SEG_BLANK;
            page_out  <= 1'b0;
        end else begin
            digit_out <= (r_scan_cnt < c_BLANK) ? 4'b1111 : ~(4'b0001 << r_digit_idx);
            seg_out   <= w_seg;
            page_out  <= r_page;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_v0_display_driver.sv
// ============================================================================
// Module      : tb_v0_display_driver
// Description : Directed scoreboard bench for the $v0 display driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_v0_display_driver;

    logic        clk = 1'b0;
    logic        reset_in = 1'b0;
    logic [31:0] value_in = 32'h0;
    logic        hold_in = 1'b0;
    logic        auto_page_in = 1'b0;
    logic        manual_page_in = 1'b0;
    logic [6:0]  seg_out;
    logic [3:0]  digit_out;
    logic        page_out;

    int n_vec  = 0;
    int n_miss = 0;

    logic [11:0] exp_q [$];

    always #5 clk = ~clk;

    v0_display_driver #(
        .SCAN_DIV     (4),
        .BLANK_CYCLES (1),
        .PAGE_FRAMES  (2)
    ) dut (
        .clk            (clk),
        .reset_in       (reset_in),
        .value_in       (value_in),
        .hold_in        (hold_in),
        .auto_page_in   (auto_page_in),
        .manual_page_in (manual_page_in),
        .seg_out        (seg_out),
        .digit_out      (digit_out),
        .page_out       (page_out)
    );

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    // One clock, then compare the DUT outputs against the oldest expectation
    task automatic tick(input string tag);
        logic [11:0] obs;
        logic [11:0] expv;
        @(posedge clk);
        #1;
        obs  = {digit_out, seg_out, page_out};
        expv = exp_q.pop_front();
        n_vec++;
        assert (obs === expv) else begin
            n_miss++;
            $error("FAIL %s observed digit=%b seg=%b page=%b expected digit=%b seg=%b page=%b",
                   tag, obs[11:8], obs[7:1], obs[0], expv[11:8], expv[7:1], expv[0]);
        end
    endtask

    // Runs n_cyc cycles of a frame that shows 'shown' on page 'pg'; the new
    // input levels are applied just before cycle chg_idx of the frame.
    task automatic run_frame(input string name, input logic [31:0] shown, input logic pg,
                             input int chg_idx, input logic [31:0] vin, input logic hold,
                             input logic autop, input logic man, input int n_cyc);
        for (int idx = 0; idx < n_cyc; idx++) begin
            int          d;
            logic [3:0]  dig;
            logic [3:0]  nib;
            if (idx == chg_idx) begin
                value_in       = vin;
                hold_in        = hold;
                auto_page_in   = autop;
                manual_page_in = man;
            end
            d   = idx / 4;
            dig = ((idx % 4) == 0) ? 4'b1111 : ~(4'b0001 << d);
            nib = shown[16*pg + 4*d +: 4];
            exp_q.push_back({dig, hex_seg(nib), pg});
            tick($sformatf("%s_c%0d", name, idx));
        end
    endtask

    initial begin
        // Reset held for three cycles
        reset_in = 1'b0;
        value_in = 32'h1234ABCD;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({4'b1111, 7'b1111111, 1'b0});
            tick($sformatf("reset%0d", i));
        end
        reset_in = 1'b1;

        // Value change while digit 2 is lit stays invisible until next frame
        run_frame("A", 32'h1234ABCD, 1'b0, 9, 32'h0, 1'b0, 1'b0, 1'b0, 16);
        run_frame("B", 32'h0,        1'b0, 0, 32'h1234ABCD, 1'b0, 1'b1, 1'b0, 16);

        // Auto paging: two frames per page
        run_frame("C", 32'h1234ABCD, 1'b0, 0, 32'h1234ABCD, 1'b0, 1'b1, 1'b0, 16);
        run_frame("D", 32'h1234ABCD, 1'b1, 0, 32'h1234ABCD, 1'b0, 1'b1, 1'b0, 16);
        run_frame("E", 32'h1234ABCD, 1'b1, 0, 32'h1234ABCD, 1'b0, 1'b1, 1'b0, 16);

        // Manual page select
        run_frame("F", 32'h1234ABCD, 1'b0, 0, 32'h1234ABCD, 1'b0, 1'b0, 1'b1, 16);

        // Hold freezes the snapshot over three boundaries
        run_frame("G", 32'h1234ABCD, 1'b1, 5, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 16);
        run_frame("H", 32'h1234ABCD, 1'b0, 0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 16);
        run_frame("I", 32'h1234ABCD, 1'b0, 0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 16);
        run_frame("J", 32'h1234ABCD, 1'b0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 16);
        run_frame("K", 32'hDEADBEEF, 1'b0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 16);

        // Reset mid-slot on digit 2 of a page-1 frame
        run_frame("L", 32'hDEADBEEF, 1'b1, 0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 10);
        reset_in       = 1'b0;
        value_in       = 32'h00C0FFEE;
        manual_page_in = 1'b0;
        exp_q.push_back({4'b1111, 7'b1111111, 1'b0});
        tick("midreset");
        reset_in = 1'b1;
        run_frame("M", 32'h00C0FFEE, 1'b0, 0, 32'h55555555, 1'b0, 1'b0, 1'b0, 16);
        run_frame("N", 32'h55555555, 1'b0, 0, 32'h55555555, 1'b0, 1'b0, 1'b0, 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
